// File: rtl/fx2_tx_arbiter.sv
// Arbitrates a streaming sample source (EP6) and packetised replies (EP8) onto one FX2 slave-FIFO write port.
// Define FX2_TX_SAMPLE_FLUSH_EN to commit partial EP6 packets after FLUSH_CYCLES idle sample cycles.
module fx2_tx_arbiter #(
  parameter int SAMPLE_BURST = 512,
  parameter int FLUSH_CYCLES = 4096
) (
  input  logic       fx2_clk,
  input  logic       reset,
  input  logic       sample_rdy,
  input  logic [7:0] sample,
  output logic       sample_ack,
  input  logic       reply_rdy,
  input  logic [7:0] reply,
  input  logic       reply_end,
  output logic       reply_ack,
  input  logic       fifo_full,
  output logic       fifo_wr,
  output logic [7:0] fifo_data,
  output logic       fifo_pktend,
  output logic [1:0] fifo_adr
);

  localparam int BW  = $clog2(SAMPLE_BURST + 1);
  localparam int BW1 = BW + 1;
  localparam logic [BW-1:0] BURST_SAT = BW'(SAMPLE_BURST);
  localparam logic [BW:0]   BURST_MAX = BW1'(SAMPLE_BURST);
  localparam logic [1:0]    EP6 = 2'b10;
  localparam logic [1:0]    EP8 = 2'b11;

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, REPLY, PKTEND} state_t;

  state_t        state_reg;
  state_t        target_reg;
  logic [BW-1:0] burst_cnt_reg;
  logic [BW:0]   burst_sum;
  logic          burst_hit;
  logic [8:0]    pkt_cnt_reg;
  logic          flush_go;

  assign sample_ack = (state_reg == SAMPLE) && sample_rdy && !fifo_full;
  assign reply_ack  = (state_reg == REPLY) && reply_rdy && !fifo_full;

  // Count the byte being acked now, so the burst ends on exactly SAMPLE_BURST writes.
  assign burst_sum = {1'b0, burst_cnt_reg} + {{BW{1'b0}}, sample_ack};
  assign burst_hit = burst_sum >= BURST_MAX;

`ifdef FX2_TX_SAMPLE_FLUSH_EN
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  logic [FW-1:0] idle_cnt_reg;
  logic          flush_idle;

  assign flush_idle = (fifo_adr == EP6) && (pkt_cnt_reg != 9'd0) && !sample_rdy &&
                      ((state_reg == IDLE) || (state_reg == SAMPLE));
  assign flush_go   = flush_idle && (idle_cnt_reg == FLUSH_LAST);

  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      idle_cnt_reg <= '0;
    end else if (!flush_idle || flush_go) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  assign flush_go = 1'b0;
`endif

  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      target_reg    <= IDLE;
      fifo_adr      <= EP6;
      fifo_wr       <= 1'b0;
      fifo_data     <= 8'h00;
      fifo_pktend   <= 1'b0;
      burst_cnt_reg <= '0;
      pkt_cnt_reg   <= 9'd0;
    end else begin
      fifo_wr     <= sample_ack || reply_ack;
      fifo_pktend <= (state_reg == PKTEND);
      if (sample_ack) begin
        fifo_data   <= sample;
        pkt_cnt_reg <= pkt_cnt_reg + 9'd1;
        if (burst_cnt_reg != BURST_SAT) begin
          burst_cnt_reg <= burst_cnt_reg + 1'b1;
        end
      end else if (reply_ack) begin
        fifo_data <= reply;
      end

      case (state_reg)
        IDLE: begin
          if (reply_rdy) begin
            if (fifo_adr != EP8) begin
              fifo_adr   <= EP8;
              target_reg <= REPLY;
              state_reg  <= SETTLE;
            end else begin
              state_reg <= REPLY;
            end
          end else if (sample_rdy) begin
            burst_cnt_reg <= '0;
            if (fifo_adr != EP6) begin
              fifo_adr   <= EP6;
              target_reg <= SAMPLE;
              state_reg  <= SETTLE;
            end else begin
              state_reg <= SAMPLE;
            end
          end else if (flush_go) begin
            state_reg <= PKTEND;
          end
        end
        SETTLE: state_reg <= target_reg;
        SAMPLE: begin
          // Leaving for a reply keeps the partial EP6 packet open in the FX2.
          if (reply_rdy && (burst_hit || !sample_rdy)) begin
            state_reg <= IDLE;
          end else if (flush_go) begin
            state_reg <= PKTEND;
          end
        end
        REPLY: begin
          if (reply_ack && reply_end) begin
            state_reg <= PKTEND;
          end
        end
        PKTEND: begin
          if (fifo_adr == EP6) begin
            pkt_cnt_reg <= 9'd0;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_tx_arbiter.sv
// Randomised and directed bench for fx2_tx_arbiter against a byte-stream scoreboard model.
module tb_fx2_tx_arbiter;

  localparam int BURST = 16;
  localparam int FLUSH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_rdy, sample_ack, reply_rdy, reply_end, reply_ack;
  logic [7:0] sample, reply, fifo_data;
  logic       fifo_full, fifo_wr, fifo_pktend;
  logic [1:0] fifo_adr;

  fx2_tx_arbiter #(.SAMPLE_BURST(BURST), .FLUSH_CYCLES(FLUSH)) dut (
    .fx2_clk(clk), .reset(reset),
    .sample_rdy(sample_rdy), .sample(sample), .sample_ack(sample_ack),
    .reply_rdy(reply_rdy), .reply(reply), .reply_end(reply_end), .reply_ack(reply_ack),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
    .fifo_pktend(fifo_pktend), .fifo_adr(fifo_adr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source queues and scoreboard state.
  logic [7:0] sq[$];
  logic [8:0] rq[$];
  bit         s_en, r_en, full_drv;
  bit         pend_v, pend_end, exp_pk, in_reply;
  logic [7:0] pend_d;
  logic [1:0] pend_a;
  int         idle_run, stp, n_sack, n_ep6, n_ep8, n_pk;

  logic       rec_wr [128];
  logic [7:0] rec_data [128];
  logic [1:0] rec_adr [128];
  logic       rec_pk [128];
  logic       rec_sa [128];
  logic       rec_ra [128];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sq.delete(); rq.delete();
    s_en = 1; r_en = 1; full_drv = 0;
    pend_v = 0; pend_end = 0; exp_pk = 0; in_reply = 0;
    idle_run = 0; stp = 0; n_sack = 0; n_ep6 = 0; n_ep8 = 0; n_pk = 0;
  endtask

  // Called on a negedge; returns on a negedge with reset released.
  task automatic do_reset();
    sample_rdy = 1; reply_rdy = 1; sample = 8'hEE; reply = 8'hDD; reply_end = 0; fifo_full = 0;
    reset = 1;
    #1;
    check("rst_wr", fifo_wr, 0);
    check("rst_data", fifo_data, 0);
    check("rst_pktend", fifo_pktend, 0);
    check("rst_adr", fifo_adr, 2'b10);
    check("rst_sack", sample_ack, 0);
    check("rst_rack", reply_ack, 0);
    repeat (2) @(negedge clk);
    reset = 0; sample_rdy = 0; reply_rdy = 0; reply_end = 0;
    clear_model();
  endtask

  // One clock: check registered outputs, drive sources, sample acks, update the model.
  task automatic step();
    check("wr", fifo_wr, pend_v);
    if (pend_v) begin
      check("data", fifo_data, pend_d);
      check("adr", fifo_adr, pend_a);
    end
    if (exp_pk) begin
      check("pktend", fifo_pktend, 1);
      check("pktend_adr", fifo_adr, 2'b11);
      check("pktend_nowr", fifo_wr, 0);
    end else if (fifo_pktend) begin
`ifdef FX2_TX_SAMPLE_FLUSH_EN
      check("flush_adr", fifo_adr, 2'b10);
      check("flush_idle", idle_run >= FLUSH, 1);
`else
      check("spurious_pktend", fifo_pktend, 0);
`endif
    end
    exp_pk = pend_v && pend_end;
    if (fifo_wr) begin
      if (fifo_adr == 2'b10) n_ep6++;
      else n_ep8++;
    end
    if (fifo_pktend) n_pk++;
    if (stp < 128) begin
      rec_wr[stp] = fifo_wr; rec_data[stp] = fifo_data;
      rec_adr[stp] = fifo_adr; rec_pk[stp] = fifo_pktend;
    end

    sample_rdy = s_en && (sq.size() != 0);
    sample     = sample_rdy ? sq[0] : 8'h00;
    reply_rdy  = r_en && (rq.size() != 0);
    reply      = reply_rdy ? rq[0][7:0] : 8'h00;
    reply_end  = reply_rdy ? rq[0][8] : 1'b0;
    fifo_full  = full_drv;
    idle_run   = sample_rdy ? 0 : idle_run + 1;
    #1;
    if (stp < 128) begin
      rec_sa[stp] = sample_ack; rec_ra[stp] = reply_ack;
    end
    if (sample_ack || reply_ack) check("ack_excl", sample_ack & reply_ack, 0);
    pend_v = 0; pend_end = 0;
    if (sample_ack) begin
      check("sack_legal", sample_rdy & !fifo_full & !in_reply, 1);
      pend_v = 1; pend_a = 2'b10; n_sack++;
      pend_d = sample;
      if (sample_rdy) void'(sq.pop_front());
    end
    if (reply_ack) begin
      check("rack_legal", reply_rdy & !fifo_full, 1);
      pend_v = 1; pend_a = 2'b11; pend_d = reply; pend_end = reply_end;
      in_reply = !reply_end;
      if (reply_rdy) void'(rq.pop_front());
    end
    stp++;
    @(negedge clk);
  endtask

  initial begin
    int first8, n6b, pos, tot_r;
    bit pushed;
    reset = 1; sample_rdy = 0; reply_rdy = 0; sample = 0; reply = 0; reply_end = 0; fifo_full = 0;
    @(negedge clk);

    // Three back-to-back samples on EP6.
    do_reset();
    sq.push_back(8'h11); sq.push_back(8'h22); sq.push_back(8'h33);
    repeat (6) step();
    check("t1_ack0", rec_sa[0], 0);
    check("t1_ack1", rec_sa[1], 1);
    check("t1_ack3", rec_sa[3], 1);
    check("t1_ack4", rec_sa[4], 0);
    check("t1_wr2", {rec_wr[2], rec_data[2]}, {1'b1, 8'h11});
    check("t1_wr4", {rec_wr[4], rec_data[4]}, {1'b1, 8'h33});
    check("t1_wr5", rec_wr[5], 0);
    check("t1_pk", n_pk, 0);

    // Two-byte reply from idle on EP6: one settle cycle, then pktend.
    do_reset();
    rq.push_back({1'b0, 8'hA1}); rq.push_back({1'b1, 8'hA2});
    repeat (8) step();
    check("t2_settle_adr", rec_adr[1], 2'b11);
    check("t2_settle_wr", rec_wr[1], 0);
    check("t2_ack2", rec_ra[2], 1);
    check("t2_wr3", {rec_wr[3], rec_data[3]}, {1'b1, 8'hA1});
    check("t2_wr4", {rec_wr[4], rec_data[4]}, {1'b1, 8'hA2});
    check("t2_pk5", {rec_pk[5], rec_wr[5]}, 2'b10);
    check("t2_pk6", rec_pk[6], 0);
    check("t2_npk", n_pk, 1);

    // Continuous samples, reply raised after 10 bytes: burst limit then reply.
    do_reset();
    for (int i = 0; i < 40; i++) sq.push_back(8'(i + 1));
    pushed = 0;
    for (int t = 0; t < 60; t++) begin
      if (!pushed && n_sack >= 10) begin
        rq.push_back({1'b0, 8'hC1}); rq.push_back({1'b0, 8'hC2}); rq.push_back({1'b1, 8'hC3});
        pushed = 1;
      end
      step();
    end
    first8 = -1; n6b = 0;
    for (int i = 0; i < 60; i++) begin
      if (first8 < 0 && rec_wr[i] && rec_adr[i] == 2'b11) first8 = i;
      else if (first8 < 0 && rec_wr[i] && rec_adr[i] == 2'b10) n6b++;
    end
    check("t3_burst_len", n6b, BURST);
    check("t3_found_reply", first8 >= 2, 1);
    if (first8 >= 2) check("t3_settle", {rec_adr[first8-2], rec_wr[first8-2]}, {2'b11, 1'b0});
    check("t3_ep6_total", n_ep6, 40);
    check("t3_ep8_total", n_ep8, 3);

    // FIFO full for 5 cycles with 0x5A pending.
    do_reset();
    sq.push_back(8'h01); sq.push_back(8'h02); sq.push_back(8'h03);
    sq.push_back(8'h5A); sq.push_back(8'h05); sq.push_back(8'h06);
    for (int t = 0; t < 14; t++) begin
      full_drv = (t >= 4 && t <= 8);
      step();
    end
    pos = 0;
    for (int i = 4; i <= 8; i++) if (rec_sa[i]) pos++;
    check("t4_stall_acks", pos, 0);
    pos = 0;
    for (int i = 5; i <= 8; i++) if (rec_wr[i]) pos++;
    check("t4_stall_wrs", pos, 0);
    pos = 0;
    for (int i = 0; i < 14; i++) if (rec_wr[i] && rec_data[i] == 8'h5A) pos++;
    check("t4_5a_once", pos, 1);
    check("t4_5a_release", {rec_wr[10], rec_data[10]}, {1'b1, 8'h5A});
    check("t4_total", n_ep6, 6);

    // Four samples then silence: flush only when enabled.
    do_reset();
    for (int i = 0; i < 4; i++) sq.push_back(8'($urandom));
    repeat (22) step();
    pos = -1;
    for (int i = 0; i < 22; i++) if (rec_pk[i] && pos < 0) pos = i;
    check("t5_ep6", n_ep6, 4);
`ifdef FX2_TX_SAMPLE_FLUSH_EN
    check("t5_flush_count", n_pk, 1);
    check("t5_flush_window", (pos >= 13) && (pos <= 15), 1);
`else
    check("t5_no_flush", n_pk, 0);
`endif

    // Reset while the second of three reply bytes is acked.
    do_reset();
    rq.push_back({1'b0, 8'hB1}); rq.push_back({1'b0, 8'hB2}); rq.push_back({1'b1, 8'hB3});
    repeat (3) step();
    reply_rdy = 1; reply = rq[0][7:0]; reply_end = rq[0][8];
    #1;
    check("t6_b2_acked", reply_ack, 1);
    do_reset();
    sq.push_back(8'h77);
    repeat (6) step();
    check("t6_sample_after", n_ep6, 1);
    check("t6_no_reply_wr", n_ep8, 0);
    check("t6_no_pktend", n_pk, 0);

    // Randomised mix of samples, reply packets, gaps and FIFO-full stalls.
    do_reset();
    tot_r = 0;
    for (int i = 0; i < 250; i++) sq.push_back(8'($urandom));
    for (int t = 0; t < 8000 && (sq.size() != 0 || rq.size() != 0); t++) begin
      s_en = ($urandom_range(0, 9) != 0);
      r_en = ($urandom_range(0, 9) != 0);
      full_drv = ($urandom_range(0, 7) == 0);
      if (rq.size() == 0 && t < 3000 && $urandom_range(0, 29) == 0) begin
        int len;
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) rq.push_back({(k == len - 1), 8'($urandom)});
        tot_r += len;
      end
      step();
    end
    check("rand_drained", sq.size() + rq.size(), 0);
    s_en = 0; full_drv = 0;
    repeat (3) step();
    check("rand_ep6", n_ep6, 250);
    check("rand_ep8", n_ep8, tot_r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
